// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern mode encodings, config layout and colour-bar lookup.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam logic [2:0] MODE_BLACK = 3'd0;
    localparam logic [2:0] MODE_BARS  = 3'd1;
    localparam logic [2:0] MODE_HRAMP = 3'd2;
    localparam logic [2:0] MODE_VRAMP = 3'd3;
    localparam logic [2:0] MODE_XOR   = 3'd4;

    typedef struct packed {
        logic       freeze;
        logic       invert;
        logic [2:0] mode;
    } cfg_t;

    // Bar index to {r,g,b} on/off: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Raster counters with combinational sync/blank decode and frame/latch strobes.
module vga_timing import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hblank_c,
    output logic          vblank_c,
    output logic          hsync_c,
    output logic          vsync_c,
    output logic          frame_tick_c,
    output logic          latch_stb_c
);

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == HW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Compares are done at 32 bits so a power-of-two total cannot alias to zero.
    always_comb begin
        hblank_c     = 32'(h) >= H_ACTIVE;
        vblank_c     = 32'(v) >= V_ACTIVE;
        hsync_c      = (32'(h) >= H_ACTIVE + H_FP && 32'(h) < H_ACTIVE + H_FP + H_SYNC)
                       ? SYNC_POL : ~SYNC_POL;
        vsync_c      = (32'(v) >= V_ACTIVE + V_FP && 32'(v) < V_ACTIVE + V_FP + V_SYNC)
                       ? SYNC_POL : ~SYNC_POL;
        frame_tick_c = (32'(h) == H_TOTAL - 1) && (32'(v) == V_TOTAL - 1);
        latch_stb_c  = (h == '0) && (32'(v) == V_ACTIVE);
    end

endmodule

// File: rtl/vga_dac_controller.sv
// VGA pattern generator: config latch, frame counter, pattern mux and registered DAC/sync outputs.
module vga_dac_controller import vga_pkg::*; #(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned BITS     = 8,
    parameter bit          SYNC_POL = 1'b0,
    localparam int unsigned HW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int unsigned VW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cfg,
    output logic [BITS-1:0] r,
    output logic [BITS-1:0] g,
    output logic [BITS-1:0] b,
    output logic [BITS-1:0] rn,
    output logic [BITS-1:0] gn,
    output logic [BITS-1:0] bn,
    output logic            hsync,
    output logic            vsync,
    output logic            hblank,
    output logic            vblank
);

    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic            hblank_c, vblank_c, hsync_c, vsync_c, frame_tick_c, latch_stb_c;
    cfg_t            cfg_q;
    logic [7:0]      frame;
    logic [BITS-1:0] x, y, f, pix_r, pix_g, pix_b;
    logic [2:0]      bar;
    logic            unused_cfg;

    assign unused_cfg = ^cfg[7:5];

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_POL(SYNC_POL)
    ) u_timing (
        .clk         (clk),
        .rst         (rst),
        .h           (h),
        .v           (v),
        .hblank_c    (hblank_c),
        .vblank_c    (vblank_c),
        .hsync_c     (hsync_c),
        .vsync_c     (vsync_c),
        .frame_tick_c(frame_tick_c),
        .latch_stb_c (latch_stb_c)
    );

    // Config is captured only at the start of vertical blank so a frame never tears.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q <= '0;
            frame <= '0;
        end else begin
            if (latch_stb_c) cfg_q <= cfg_t'(cfg[4:0]);
            if (frame_tick_c && !cfg_q.freeze) frame <= frame + 8'd1;
        end
    end

    always_comb begin
        x     = BITS'(h);
        y     = BITS'(v);
        f     = BITS'(frame);
        bar   = bar_rgb(3'((32'(h) * 32'd8) / H_ACTIVE));
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        case (cfg_q.mode)
            MODE_BARS: begin
                pix_r = {BITS{bar[2]}};
                pix_g = {BITS{bar[1]}};
                pix_b = {BITS{bar[0]}};
            end
            MODE_HRAMP: begin
                pix_r = x;
                pix_g = x;
                pix_b = x;
            end
            MODE_VRAMP: begin
                pix_r = y;
                pix_g = y;
                pix_b = y;
            end
            MODE_XOR: begin
                pix_r = x ^ y;
                pix_g = x ^ (y + f);
                pix_b = x + f;
            end
            default: ;
        endcase
        if (cfg_q.invert) begin
            pix_r = ~pix_r;
            pix_g = ~pix_g;
            pix_b = ~pix_b;
        end
        // Blanking overrides both mode and invert.
        if (hblank_c || vblank_c) begin
            pix_r = '0;
            pix_g = '0;
            pix_b = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r      <= '0;
            g      <= '0;
            b      <= '0;
            rn     <= '1;
            gn     <= '1;
            bn     <= '1;
            hsync  <= ~SYNC_POL;
            vsync  <= ~SYNC_POL;
            hblank <= 1'b1;
            vblank <= 1'b1;
        end else begin
            r      <= pix_r;
            g      <= pix_g;
            b      <= pix_b;
            rn     <= ~pix_r;
            gn     <= ~pix_g;
            bn     <= ~pix_b;
            hsync  <= hsync_c;
            vsync  <= vsync_c;
            hblank <= hblank_c;
            vblank <= vblank_c;
        end
    end

endmodule

// File: tb/tb_vga_dac_controller.sv
// Scoreboard bench: small-raster instance (BITS=4) and wide-line instance (BITS=8) with directed pixel checks.
module tb_vga_dac_controller;

    localparam int F_R = 0, F_G = 1, F_B = 2, F_RN = 3, F_GN = 4, F_BN = 5;
    localparam int F_HS = 6, F_VS = 7, F_HB = 8, F_VB = 9;

    typedef struct {
        int    idx;
        int    fld;
        int    want;
        string name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s, rst_w;
    logic [7:0] cfg_s, cfg_w;
    logic [3:0] r_s, g_s, b_s, rn_s, gn_s, bn_s;
    logic [7:0] r_w, g_w, b_w, rn_w, gn_w, bn_w;
    logic       hs_s, vs_s, hb_s, vb_s, hs_w, vs_w, hb_w, vb_w;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_s = 0;
    int   n_w = 0;
    bit   done_s = 1'b0;
    bit   done_w = 1'b0;
    exp_t q_s[$];
    exp_t q_w[$];

    vga_dac_controller #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BITS(4), .SYNC_POL(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst_s), .cfg(cfg_s),
        .r(r_s), .g(g_s), .b(b_s), .rn(rn_s), .gn(gn_s), .bn(bn_s),
        .hsync(hs_s), .vsync(vs_s), .hblank(hb_s), .vblank(vb_s)
    );

    vga_dac_controller #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BITS(8), .SYNC_POL(1'b0)
    ) dut_w (
        .clk(clk), .rst(rst_w), .cfg(cfg_w),
        .r(r_w), .g(g_w), .b(b_w), .rn(rn_w), .gn(gn_w), .bn(bn_w),
        .hsync(hs_w), .vsync(vs_w), .hblank(hb_w), .vblank(vb_w)
    );

    // Output after edge n (counted from reset release) shows pixel n-1.
    always @(posedge clk) n_s <= rst_s ? 0 : n_s + 1;
    always @(posedge clk) n_w <= rst_w ? 0 : n_w + 1;

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    function automatic int obs_s(input int fld);
        case (fld)
            F_R:  return 32'(r_s);
            F_G:  return 32'(g_s);
            F_B:  return 32'(b_s);
            F_RN: return 32'(rn_s);
            F_GN: return 32'(gn_s);
            F_BN: return 32'(bn_s);
            F_HS: return 32'(hs_s);
            F_VS: return 32'(vs_s);
            F_HB: return 32'(hb_s);
            default: return 32'(vb_s);
        endcase
    endfunction

    function automatic int obs_w(input int fld);
        case (fld)
            F_R:  return 32'(r_w);
            F_G:  return 32'(g_w);
            F_B:  return 32'(b_w);
            F_RN: return 32'(rn_w);
            F_GN: return 32'(gn_w);
            F_BN: return 32'(bn_w);
            F_HS: return 32'(hs_w);
            F_VS: return 32'(vs_w);
            F_HB: return 32'(hb_w);
            default: return 32'(vb_w);
        endcase
    endfunction

    task automatic ps(input int idx, input int fld, input int want, input string name);
        q_s.push_back('{idx: idx, fld: fld, want: want, name: name});
    endtask

    task automatic pw(input int idx, input int fld, input int want, input string name);
        q_w.push_back('{idx: idx, fld: fld, want: want, name: name});
    endtask

    task automatic wait_s(input int p);
        while (n_s - 1 < p) @(negedge clk);
    endtask

    task automatic wait_w(input int p);
        while (n_w - 1 < p) @(negedge clk);
    endtask

    task automatic reset_check_s(input string tag);
        check({tag, "_r"},  32'(r_s),  0);
        check({tag, "_rn"}, 32'(rn_s), 15);
        check({tag, "_hs"}, 32'(hs_s), 1);
        check({tag, "_vs"}, 32'(vs_s), 1);
        check({tag, "_hb"}, 32'(hb_s), 1);
        check({tag, "_vb"}, 32'(vb_s), 1);
    endtask

    // Monitors: pop every expectation due at the pixel currently on the outputs.
    always @(negedge clk) begin
        if (!rst_s && n_s > 0) begin
            while (q_s.size() > 0 && q_s[0].idx <= n_s - 1) begin
                exp_t e;
                e = q_s.pop_front();
                if (e.idx < n_s - 1) check({"s_missed_", e.name}, n_s - 1, e.idx);
                else                 check({"s_", e.name}, obs_s(e.fld), e.want);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_w && n_w > 0) begin
            while (q_w.size() > 0 && q_w[0].idx <= n_w - 1) begin
                exp_t e;
                e = q_w.pop_front();
                if (e.idx < n_w - 1) check({"w_missed_", e.name}, n_w - 1, e.idx);
                else                 check({"w_", e.name}, obs_w(e.fld), e.want);
            end
        end
    end

    // Small raster: 14 clocks/line, 7 lines/frame, 98 pixels/frame.
    initial begin : stim_s
        rst_s = 1'b1;
        cfg_s = 8'h02;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_check_s("rst0");
        ps(0, F_HB, 0, "hb_p0");     ps(0, F_VB, 0, "vb_p0");
        ps(0, F_HS, 1, "hs_p0");     ps(3, F_R, 0, "f0_black");
        ps(7, F_HB, 0, "hb_h7");     ps(8, F_HB, 1, "hb_h8");
        ps(9, F_HS, 1, "hs_h9");     ps(10, F_HS, 0, "hs_h10");
        ps(11, F_HS, 0, "hs_h11");   ps(12, F_HS, 1, "hs_h12");
        ps(24, F_HS, 0, "hs_l1h10"); ps(55, F_VB, 0, "vb_l3");
        ps(56, F_VB, 1, "vb_l4");    ps(69, F_VS, 1, "vs_l4end");
        ps(70, F_VS, 0, "vs_l5");    ps(80, F_HS, 0, "hs_l5h10");
        ps(83, F_VS, 0, "vs_l5end"); ps(84, F_VS, 1, "vs_l6");
        ps(101, F_R, 3, "hr_r");     ps(101, F_G, 3, "hr_g");
        ps(101, F_B, 3, "hr_b");     ps(101, F_RN, 12, "hr_rn");
        ps(105, F_R, 7, "hr_h7");    ps(106, F_R, 0, "hr_blank_r");
        ps(106, F_RN, 15, "hr_blank_rn");
        ps(131, F_R, 5, "no_early_latch");
        ps(196, F_R, 0, "xor00_r");  ps(196, F_G, 2, "xor00_g");
        ps(196, F_B, 2, "xor00_b");  ps(213, F_R, 2, "xor31_r");
        ps(213, F_G, 0, "xor31_g");  ps(213, F_B, 5, "xor31_b");
        ps(294, F_B, 3, "frame3");   ps(490, F_B, 5, "frame5");
        ps(588, F_R, 15, "inv_r");   ps(588, F_G, 10, "inv_g");
        ps(588, F_B, 10, "frz6_b");  ps(588, F_RN, 0, "inv_rn");
        ps(588, F_GN, 5, "inv_gn");  ps(596, F_R, 0, "inv_blank_r");
        ps(596, F_RN, 15, "inv_blank_rn");
        ps(686, F_B, 10, "frz7_b");  ps(784, F_B, 10, "frz8_b");
        ps(882, F_B, 6, "resume_b"); ps(882, F_R, 0, "resume_r");
        ps(980, F_B, 7, "frame_next");
        ps(25872, F_B, 5, "wrap_prev");
        ps(25970, F_B, 6, "wrap_b"); ps(25970, F_G, 6, "wrap_g");
        rst_s = 1'b0;
        wait_s(112);  cfg_s = 8'h04;
        wait_s(500);  cfg_s = 8'h1C;
        wait_s(800);  cfg_s = 8'h04;
        wait_s(26049);
        rst_s = 1'b1;
        @(negedge clk);
        reset_check_s("rstmid");
        ps(0, F_HB, 0, "rs_hb");     ps(0, F_VB, 0, "rs_vb");
        ps(3, F_R, 0, "rs_black_h3"); ps(10, F_HS, 0, "rs_hs_h10");
        ps(17, F_R, 0, "rs_r");      ps(17, F_G, 0, "rs_g");
        ps(17, F_B, 0, "rs_b");      ps(98, F_G, 1, "rs_relatch_g");
        ps(98, F_B, 1, "rs_relatch_b");
        rst_s = 1'b0;
        wait_s(120);
        done_s = 1'b1;
    end

    // Wide raster: 800 clocks/line, 5 lines/frame, 4000 pixels/frame.
    initial begin : stim_w
        rst_w = 1'b1;
        cfg_w = 8'h02;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("w_rst_r",  32'(r_w),  0);
        check("w_rst_rn", 32'(rn_w), 255);
        check("w_rst_hs", 32'(hs_w), 1);
        check("w_rst_vb", 32'(vb_w), 1);
        pw(300, F_R, 0, "f0_black");
        pw(4300, F_R, 44, "h300_r");   pw(4300, F_G, 44, "h300_g");
        pw(4300, F_B, 44, "h300_b");   pw(4300, F_RN, 211, "h300_rn");
        pw(4300, F_GN, 211, "h300_gn"); pw(4300, F_BN, 211, "h300_bn");
        pw(4700, F_R, 0, "blank_r");   pw(4700, F_RN, 255, "blank_rn");
        pw(4700, F_HB, 1, "blank_hb"); pw(5100, F_R, 44, "no_early_latch");
        pw(8000, F_R, 255, "white_r"); pw(8000, F_G, 255, "white_g");
        pw(8000, F_B, 255, "white_b"); pw(8079, F_B, 255, "white_end_b");
        pw(8080, F_R, 255, "yel_r");   pw(8080, F_G, 255, "yel_g");
        pw(8080, F_B, 0, "yel_b");     pw(8160, F_R, 0, "cyan_r");
        pw(8160, F_G, 255, "cyan_g");  pw(8160, F_B, 255, "cyan_b");
        pw(8559, F_R, 0, "blue_r");    pw(8559, F_B, 255, "blue_b");
        pw(8560, F_B, 0, "black_b");   pw(8655, F_HS, 1, "hs_h655");
        pw(8656, F_HS, 0, "hs_h656");  pw(8751, F_HS, 0, "hs_h751");
        pw(8752, F_HS, 1, "hs_h752");
        rst_w = 1'b0;
        wait_w(4100); cfg_w = 8'h01;
        wait_w(8800);
        done_w = 1'b1;
    end

    initial begin : finish_blk
        wait (done_s && done_w);
        @(negedge clk);
        while (q_s.size() > 0) begin
            exp_t e;
            e = q_s.pop_front();
            check({"s_never_seen_", e.name}, n_s - 1, e.idx);
        end
        while (q_w.size() > 0) begin
            exp_t e;
            e = q_w.pop_front();
            check({"w_never_seen_", e.name}, n_w - 1, e.idx);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        n_err++;
        $display("FAIL watchdog: stimulus did not complete within the time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_dac_controller.md
# vga_dac_controller

Parametrised VGA timing and pattern generator that drives the on-chip current-steering R/G/B DACs with true and complementary bit buses. Successor to the fixed 640x480, 8-bit-per-channel controller. Adds:
- generic timing and channel width (BITS)
- selectable sync polarity
- frame-latched pattern modes
- an animation frame counter

It sits between the tile's digital inputs and the analog DAC macros. Sync/blank outputs go to the digital pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- BITS, 8, DAC bits per channel (2..8)
- SYNC_POL, 0, sync asserted level (0 = active-low)

Ports:
- clk  in  1  pixel clock; one clock, everything synchronous to its rising edge
- rst  in  1  synchronous, active-high reset
- cfg  in  8  [2:0] mode, [3] invert, [4] freeze animation, [7:5] ignored
- r, g, b  out  BITS each  DAC true (steer-to-output) bits
- rn, gn, bn  out  BITS each  DAC complementary bits; always bitwise ~r / ~g / ~b
- hsync, vsync  out  1 each  sync, level per SYNC_POL
- hblank, vblank  out  1 each  active-high blanking flags

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Counter widths are $clog2 of each total.
- h counts 0..H_TOTAL-1, then wraps to 0 and advances v.
- v wraps from V_TOTAL-1 to 0.
- hblank = h >= H_ACTIVE; vblank = v >= V_ACTIVE.
- hsync is asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
- vsync is asserted for whole lines V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, with edges at h=0.
- Config latch: cfg is sampled into an internal register only at h=0, v=V_ACTIVE (start of vertical blank). Changes at any other time have no effect until that point.
- Frame counter: 8 bits. Increments at h=H_TOTAL-1, v=V_TOTAL-1 unless latched freeze=1. Wraps 255->0.
- Modes (latched). In all formulas, x = h[BITS-1:0], y = v[BITS-1:0], f = frame[BITS-1:0], and MAX = all ones.
  - 0: black.
  - 1: 8 colour bars, bar index i = h*8/H_ACTIVE. Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is MAX or 0.
  - 2: horizontal grey ramp, r=g=b=x.
  - 3: vertical grey ramp, r=g=b=y.
  - 4: XOR plasma, r=x^y, g=x^(y+f), b=x+f.
  - 5..7: black.
- Invert (latched): XORs r/g/b with MAX in active region only.
- Blanking: whenever hblank or vblank, r=g=b=0 and rn=gn=bn=MAX, regardless of mode or invert.
- Arithmetic is modulo 2^BITS and truncates; no saturation.

## Timing
- Counter state in cycle t produces registered outputs in cycle t+1.
- All outputs (colour, complement, sync, blank) are aligned to the same edge. Latency is one clock.
- While rst is high, at the next edge:
  - h, v, frame become 0
  - latched cfg becomes 0
  - r/g/b become 0 and rn/gn/bn become MAX
  - hsync/vsync go to the inactive level
  - hblank=vblank=1
- First clock after rst falls: counters at (0,0). Outputs show pixel (0,0) one clock later.
- Reset mid-frame behaves identically and restarts at (0,0). No partial line is preserved.
- Latch edge: if cfg changes in the same cycle as h=0, v=V_ACTIVE, the new value is captured. It takes effect on v=0 of the next frame, since the remaining lines are blanked.
- Frame increment and v wrap occur on the same edge; pixel (0,0) of the new frame already uses the new frame value.

## Structure
- Package vga_pkg:
  - default timing constants
  - mode encoding constants MODE_BLACK, MODE_BARS, MODE_HRAMP, MODE_VRAMP, MODE_XOR
  - colour-bar lookup function
- Sub-module vga_timing: h/v counters, sync/blank decode, frame-tick and latch-strobe pulses.
  - Parameters are the timing set plus SYNC_POL.
- Top vga_dac_controller: config latch, frame counter, pattern mux, output registers and complement generation.

## Test plan
- Small timing (H 8/2/2/2, V 4/1/1/1, BITS=4), reset released → hsync low for exactly 2 clocks every 14, vsync low for 1 line every 7 lines, both as first seen on outputs one clock after counter state.
- Mode 2, BITS=8, default timing → pixel h=300 outputs r=g=b=44, rn=gn=bn=211. In blanking, r=0 and rn=255.
- Mode 1 → h=0..79 white (255,255,255), h=560..639 black, and h=80 yellow (255,255,0).
- cfg changed from mode 2 to 4 at v=100 → no change until next frame. After latch, pixel (0,0) shows r=0, g=f, b=f.
- Freeze=1 latched at frame 5 → frame stays 5 across 3 frames. Clearing freeze resumes counting; after 256 increments the value wraps back to the same value.
- Assert rst for 1 clock at h=400, v=200 → next edge outputs blanked with syncs inactive; counters then restart at (0,0) and cfg latch reads mode 0 (black).
